// File: rtl/store_axiw.sv
// Store buffer draining in-order single AXI4-Lite writes, one outstanding at a time.
// Optional STORE_BRESP_CHECK_EN: a non-OKAY BRESP sets the sticky ST_ERR flag.
`ifndef XLEN
`define XLEN 32
`endif

module store_axiw #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 ST_VALID,
  output logic                 ST_READY,
  input  logic [`XLEN-1:0]     ST_ADDR,
  input  logic [`XLEN-1:0]     ST_DATA,
  input  logic [`XLEN/8-1:0]   ST_STRB,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [`XLEN-1:0]     AWADDR,
  output logic [2:0]           AWPROT,
  output logic                 WVALID,
  input  logic                 WREADY,
  output logic [`XLEN-1:0]     WDATA,
  output logic [`XLEN/8-1:0]   WSTRB,
  input  logic                 BVALID,
  output logic                 BREADY,
  input  logic [1:0]           BRESP,
  output logic                 IDLE,
  output logic                 ST_ERR
);

  localparam int unsigned XLEN = `XLEN;
  localparam int unsigned SW   = XLEN / 8;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [SW-1:0]   strb;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR_DATA, S_WAIT_B} state_t;

  state_t          state, state_next;
  entry_t          mem [DEPTH];
  entry_t          head_next;
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]   count, count_pop, count_next;
  logic            aw_done, w_done, aw_done_next, w_done_next;
  logic            push, pop, aw_hs, w_hs, load;

  assign push        = ST_VALID && ST_READY;
  assign pop         = BVALID && BREADY;
  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign rd_ptr_next = rd_ptr + PW'(pop);
  assign count_pop   = count - CW'(pop);
  assign count_next  = count_pop + CW'(push);
  assign AWPROT      = 3'b000;

  // Next head payload; bypasses the incoming store when the buffer would otherwise be empty.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (count_pop == CW'(0)) begin
      head_next.addr = ST_ADDR;
      head_next.data = ST_DATA;
      head_next.strb = ST_STRB;
    end
  end

  // Next-state logic with independent AW/W completion tracking.
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    load         = 1'b0;
    case (state)
      S_IDLE: begin
        if (count_next != CW'(0)) begin
          state_next   = S_ADDR_DATA;
          load         = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      S_ADDR_DATA: begin
        aw_done_next = aw_done || aw_hs;
        w_done_next  = w_done || w_hs;
        if (aw_done_next && w_done_next) begin
          state_next   = S_WAIT_B;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      S_WAIT_B: begin
        if (pop) begin
          if (count_next != CW'(0)) begin
            state_next = S_ADDR_DATA;
            load       = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ST_READY <= 1'b1;
      AWVALID  <= 1'b0;
      WVALID   <= 1'b0;
      BREADY   <= 1'b0;
      IDLE     <= 1'b1;
      AWADDR   <= '0;
      WDATA    <= '0;
      WSTRB    <= '0;
    end else begin
      state    <= state_next;
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
      ST_READY <= (count_next != CW'(DEPTH));
      AWVALID  <= (state_next == S_ADDR_DATA) && !aw_done_next;
      WVALID   <= (state_next == S_ADDR_DATA) && !w_done_next;
      BREADY   <= (state_next == S_WAIT_B);
      IDLE     <= (count_next == CW'(0)) && (state_next == S_IDLE);
      if (load) begin
        AWADDR <= head_next.addr;
        WDATA  <= head_next.data;
        WSTRB  <= head_next.strb;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{addr: ST_ADDR, data: ST_DATA, strb: ST_STRB};
  end

`ifdef STORE_BRESP_CHECK_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ST_ERR <= 1'b0;
    end else if (pop && (BRESP != 2'b00)) begin
      ST_ERR <= 1'b1;
    end
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^BRESP;
  assign ST_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_store_axiw.sv
// Directed bench for store_axiw (DEPTH=2, XLEN=32); expected values hand-computed per step.
module tb_store_axiw;

  logic        CLK, RSTn;
  logic        ST_VALID, ST_READY;
  logic [31:0] ST_ADDR, ST_DATA;
  logic [3:0]  ST_STRB;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        IDLE, ST_ERR;

  int tests = 0;
  int fails = 0;

`ifdef STORE_BRESP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  store_axiw #(.DEPTH(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ST_VALID(ST_VALID), .ST_READY(ST_READY),
    .ST_ADDR(ST_ADDR), .ST_DATA(ST_DATA), .ST_STRB(ST_STRB),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .IDLE(IDLE), .ST_ERR(ST_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".st_ready"}, ST_READY, 1);
    chk({tag, ".awvalid"}, AWVALID, 0);
    chk({tag, ".wvalid"}, WVALID, 0);
    chk({tag, ".bready"}, BREADY, 0);
    chk({tag, ".idle"}, IDLE, 1);
    chk({tag, ".awaddr"}, AWADDR, 0);
    chk({tag, ".wdata"}, WDATA, 0);
    chk({tag, ".wstrb"}, WSTRB, 0);
    chk({tag, ".st_err"}, ST_ERR, 0);
    chk({tag, ".awprot"}, AWPROT, 0);
  endtask

  initial begin
    RSTn = 1'b0; ST_VALID = 1'b0; ST_ADDR = '0; ST_DATA = '0; ST_STRB = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    step(); step();
    chk_reset_outputs("reset");
    @(negedge CLK); RSTn = 1'b1;
    step();
    chk("post_rst.idle", IDLE, 1);

    // Single store, slave always ready, BVALID held high (ignored until WAIT_B).
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
    ST_VALID = 1'b1; ST_ADDR = 32'h0000_1000; ST_DATA = 32'hDEAD_BEEF; ST_STRB = 4'hF;
    step();
    ST_VALID = 1'b0;
    chk("single.awvalid", AWVALID, 1);
    chk("single.wvalid", WVALID, 1);
    chk("single.awaddr", AWADDR, 32'h0000_1000);
    chk("single.wdata", WDATA, 32'hDEAD_BEEF);
    chk("single.wstrb", WSTRB, 4'hF);
    chk("single.bready_early", BREADY, 0);
    chk("single.idle_busy", IDLE, 0);
    step();
    chk("single.bready", BREADY, 1);
    chk("single.aw_drop", AWVALID, 0);
    chk("single.w_drop", WVALID, 0);
    step();
    BVALID = 1'b0;
    chk("single.idle_done", IDLE, 1);
    chk("single.bready_off", BREADY, 0);

    // AW stalled, W completes first; AWADDR must hold until its own handshake.
    AWREADY = 1'b0; WREADY = 1'b1;
    ST_VALID = 1'b1; ST_ADDR = 32'h0000_2000; ST_DATA = 32'h1234_5678; ST_STRB = 4'h3;
    step();
    ST_VALID = 1'b0;
    chk("awstall.both_valid", {AWVALID, WVALID}, 2'b11);
    step();
    chk("awstall.w_done", WVALID, 0);
    chk("awstall.aw_hold", AWVALID, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("awstall.aw_hold_loop", AWVALID, 1);
      chk("awstall.addr_stable", AWADDR, 32'h0000_2000);
      chk("awstall.no_wait_b", BREADY, 0);
      chk("awstall.w_stays_low", WVALID, 0);
    end
    AWREADY = 1'b1;
    step();
    chk("awstall.wait_b", BREADY, 1);
    chk("awstall.aw_drop", AWVALID, 0);
    chk("awstall.wstrb", WSTRB, 4'h3);
    BVALID = 1'b1; BRESP = 2'b10;
    step();
    BVALID = 1'b0; BRESP = 2'b00;
    chk("bresp.idle", IDLE, 1);
    chk("bresp.st_err", ST_ERR, ERR_EXP);
    step();
    chk("bresp.sticky", ST_ERR, ERR_EXP);

    // Backpressure: three stores into DEPTH=2 with B withheld, in-order issue.
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0;
    ST_VALID = 1'b1; ST_ADDR = 32'h0000_3000; ST_DATA = 32'hA000_0000; ST_STRB = 4'h1;
    step();
    chk("fill.ready1", ST_READY, 1);
    chk("fill.addr_a", AWADDR, 32'h0000_3000);
    ST_ADDR = 32'h0000_3004; ST_DATA = 32'hB000_0000; ST_STRB = 4'h2;
    step();
    chk("fill.full", ST_READY, 0);
    chk("fill.wait_b_a", BREADY, 1);
    ST_ADDR = 32'h0000_3008; ST_DATA = 32'hC000_0000; ST_STRB = 4'h4;
    step();
    chk("fill.still_full", ST_READY, 0);
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    chk("fill.ready_after_b", ST_READY, 1);
    chk("fill.addr_b", AWADDR, 32'h0000_3004);
    chk("fill.data_b", WDATA, 32'hB000_0000);
    chk("fill.awvalid_b", AWVALID, 1);
    step();
    ST_VALID = 1'b0;
    chk("fill.third_accepted", ST_READY, 0);
    chk("fill.wait_b_b", BREADY, 1);
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    chk("fill.addr_c", AWADDR, 32'h0000_3008);
    chk("fill.strb_c", WSTRB, 4'h4);
    chk("fill.ready_c", ST_READY, 1);
    step();
    chk("fill.wait_b_c", BREADY, 1);
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    chk("fill.idle", IDLE, 1);
    chk("fill.err_sticky", ST_ERR, ERR_EXP);

    // Reset while waiting for B with two entries buffered.
    ST_VALID = 1'b1; ST_ADDR = 32'h0000_4000; ST_DATA = 32'hD000_0000; ST_STRB = 4'hF;
    step();
    ST_ADDR = 32'h0000_4004; ST_DATA = 32'hE000_0000;
    step();
    ST_VALID = 1'b0;
    chk("rstmid.wait_b", BREADY, 1);
    chk("rstmid.full", ST_READY, 0);
    #2 RSTn = 1'b0;
    #1;
    chk_reset_outputs("rstmid");
    @(negedge CLK); RSTn = 1'b1;
    step();
    chk("rstmid.idle_after", IDLE, 1);
    chk("rstmid.ready_after", ST_READY, 1);
    step();
    chk("rstmid.abandoned", AWVALID, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
